// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package fetch_pkg;

    localparam int ADDR_W_DEF     = 8;
    localparam int INSTR_W_DEF    = 8;
    localparam int FIFO_DEPTH_DEF = 2;

    // FETCH issues ROM reads; HALTED keeps the PC frozen and issues nothing.
    typedef enum logic [0:0] {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO holding {instruction, pc} pairs.
// Flush empties the buffer and wins over a same-cycle push. The head reads as zero while empty.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointer and occupancy bookkeeping; DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage write port.
    always_ff @(posedge clock) begin
        // NOTE: storage has no reset; the occupancy count alone decides what is valid.
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign head  = empty ? '0 : mem[rd_ptr];

endmodule : fetch_fifo

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle-latency ROM, buffers the returned
// words and hands them to decode over valid/ready. Redirect flushes the wrong-path words.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int INSTR_W    = INSTR_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_t       state;
    fetch_state_t       state_next;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  tag;
    logic               inflight;
    logic               kill;
    logic               issue;
    logic               push;
    logic               pop;
    logic               credit_ok;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     used;
    logic [CNT_W:0]     limit;
    logic               full;
    logic               empty;
    logic [INSTR_W+ADDR_W-1:0] head;

    assign pop         = instr_valid & instr_ready;
    assign instr_valid = !empty;
    assign {instr, instr_pc} = head;

    // A redirect on the cycle the pending word lands drops that word.
    assign kill = redirect & inflight;
    assign push = inflight & !kill;

    // A slot popped this cycle frees up at the same edge the new read is issued, so it counts
    // as credit; that is what lets a two-entry buffer sustain one instruction per cycle.
    assign used      = {1'b0, count} + (CNT_W+1)'(inflight);
    assign limit     = (CNT_W+1)'(FIFO_DEPTH) + (CNT_W+1)'(pop);
    assign credit_ok = (used < limit);

    // Next-state and issue decision; redirect outranks halt and always returns to FETCH.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_next = state;
        issue      = 1'b0;
        case (state)
            FETCH:   if (halt && !redirect)  state_next = HALTED;
            HALTED:  if (!halt || redirect)  state_next = FETCH;
            default: state_next = FETCH;
        endcase
        if (reset_n && (state == FETCH) && !halt && !redirect && credit_ok) issue = 1'b1;
    end

    assign mem_rd   = issue;
    assign mem_addr = pc;

    // PC, state and pending-read tracking.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= FETCH;
            pc       <= '0;
            tag      <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= issue;
            if (issue) tag <= pc;
            if (redirect)   pc <= redirect_pc;
            else if (issue) pc <= pc + ADDR_W'(1);
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (INSTR_W + ADDR_W)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({mem_data, tag}),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // A landing word must always find a free slot.
    assert property (@(posedge clock) disable iff (!reset_n) !(push && full && !pop && !redirect));

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic       clock;
    logic       reset_n;
    logic       mem_rd;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       halt;

    int total;
    int bad;
    bit check_en;

    fetch_unit #(
        .ADDR_W     (8),
        .INSTR_W    (8),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Program ROM contents: word at address a is a + 0x10.
    function automatic logic [7:0] rom_word(input logic [7:0] a);
        return a + 8'h10;
    endfunction

    // One-cycle-latency ROM.
    always @(posedge clock) begin
        if (mem_rd === 1'b1) mem_data <= rom_word(mem_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0] word;
        logic [7:0] pc;
    } entry_t;

    entry_t     m_q[$];     // words buffered for decode, oldest first
    bit         m_fly;      // a read was issued last cycle and lands this cycle
    logic [7:0] m_fly_pc;
    logic [7:0] m_pc;       // next address to fetch
    bit         m_halted;

    function automatic bit model_pop();
        return (m_q.size() != 0) && (instr_ready === 1'b1);
    endfunction

    // Issue whenever fetching is allowed and the word will have a slot to land in.
    function automatic bit model_rd();
        int pending;
        int room;
        pending = m_q.size() + (m_fly ? 1 : 0);
        room    = DEPTH + (model_pop() ? 1 : 0);
        return (reset_n === 1'b1) && !m_halted && (halt !== 1'b1) && (redirect !== 1'b1)
               && (pending < room);
    endfunction

    always @(posedge clock) begin : model_update
        bit rd_now;
        bit pop_now;
        if (reset_n !== 1'b1) begin
            m_q.delete();
            m_fly    = 1'b0;
            m_fly_pc = 8'h00;
            m_pc     = 8'h00;
            m_halted = 1'b0;
        end else begin
            rd_now  = model_rd();
            pop_now = model_pop();
            if (pop_now) void'(m_q.pop_front());
            if (redirect === 1'b1) m_q.delete();
            else if (m_fly) m_q.push_back(entry_t'{word: rom_word(m_fly_pc), pc: m_fly_pc});
            m_fly    = rd_now;
            m_fly_pc = m_pc;
            if (redirect === 1'b1) m_pc = redirect_pc;
            else if (rd_now)       m_pc = m_pc + 8'h01;
            m_halted = (halt === 1'b1) && (redirect !== 1'b1);
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clock) begin
        if (check_en) begin
            check("mem_rd", mem_rd, model_rd());
            if (model_rd()) check("mem_addr", mem_addr, m_pc);
            check("instr_valid", instr_valid, m_q.size() != 0);
            if (m_q.size() != 0) begin
                check("instr", instr, m_q[0].word);
                check("instr_pc", instr_pc, m_q[0].pc);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        int n_rd;
        logic [15:0] ready_pat;
        reset_n     = 1'b0;
        instr_ready = 1'b1;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        mem_data    = 8'h00;
        check_en    = 1'b0;
        total       = 0;
        bad         = 0;
        ready_pat   = 16'b1011_0010_1110_0101;

        step(2);
        check_en = 1'b1;
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_mem_rd", mem_rd, 0);

        // 1: release reset, stream with ready=1
        reset_n = 1'b1;
        #1;
        check("t1_rd_c0", mem_rd, 1);
        check("t1_addr_c0", mem_addr, 8'h00);
        check("t1_valid_c0", instr_valid, 0);
        step(1);
        check("t1_addr_c1", mem_addr, 8'h01);
        check("t1_valid_c1", instr_valid, 0);
        step(1);
        check("t1_valid_c2", instr_valid, 1);
        check("t1_instr_c2", instr, 8'h10);
        check("t1_pc_c2", instr_pc, 8'h00);
        check("t1_addr_c2", mem_addr, 8'h02);
        step(1);
        check("t1_instr_c3", instr, 8'h11);
        check("t1_pc_c3", instr_pc, 8'h01);
        step(6);

        // 2: decode stalled from reset for 5 cycles
        reset_n     = 1'b0;
        instr_ready = 1'b0;
        step(1);
        reset_n = 1'b1;
        n_rd    = 0;
        repeat (5) begin
            @(negedge clock);
            if (mem_rd === 1'b1) n_rd++;
        end
        check("t2_reads", n_rd, DEPTH);
        check("t2_hold_valid", instr_valid, 1);
        check("t2_hold_instr", instr, 8'h10);
        check("t2_hold_pc", instr_pc, 8'h00);
        step(1);
        instr_ready = 1'b1;
        #1;
        check("t2_resume_rd", mem_rd, 1);
        check("t2_resume_addr", mem_addr, 8'h02);
        step(8);
        for (int i = 0; i < 16; i++) begin
            instr_ready = ready_pat[i];
            step(1);
        end
        instr_ready = 1'b1;
        step(3);

        // 3: redirect with buffer full, then redirect with a same-cycle pop
        instr_ready = 1'b0;
        step(3);
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        step(1);
        redirect    = 1'b0;
        instr_ready = 1'b1;
        #1;
        check("t3_valid_r1", instr_valid, 0);
        check("t3_rd_r1", mem_rd, 1);
        check("t3_addr_r1", mem_addr, 8'h40);
        step(1);
        check("t3_valid_r2", instr_valid, 0);
        step(1);
        check("t3_valid_r3", instr_valid, 1);
        check("t3_pc_r3", instr_pc, 8'h40);
        check("t3_instr_r3", instr, 8'h50);
        step(4);
        redirect    = 1'b1;
        redirect_pc = 8'h80;
        step(1);
        redirect = 1'b0;
        #1;
        check("t3b_valid_r1", instr_valid, 0);
        step(1);
        check("t3b_valid_r2", instr_valid, 0);
        step(1);
        check("t3b_pc_r3", instr_pc, 8'h80);
        check("t3b_instr_r3", instr, 8'h90);
        step(2);

        // 4: PC wrap
        redirect    = 1'b1;
        redirect_pc = 8'hFE;
        step(1);
        redirect = 1'b0;
        #1;
        check("t4_addr_fe", mem_addr, 8'hFE);
        step(1);
        check("t4_addr_ff", mem_addr, 8'hFF);
        step(1);
        check("t4_addr_00", mem_addr, 8'h00);
        check("t4_pc_fe", instr_pc, 8'hFE);
        check("t4_instr_fe", instr, 8'h0E);
        step(1);
        check("t4_pc_ff", instr_pc, 8'hFF);
        check("t4_instr_ff", instr, 8'h0F);
        step(1);
        check("t4_pc_00", instr_pc, 8'h00);
        check("t4_instr_00", instr, 8'h10);
        step(2);

        // 5: halt drains, resume at frozen pc, redirect while halted
        redirect    = 1'b1;
        redirect_pc = 8'h20;
        step(1);
        redirect = 1'b0;
        step(3);
        halt = 1'b1;
        #1;
        check("t5_rd_h0", mem_rd, 0);
        check("t5_pc_h0", instr_pc, 8'h21);
        n_rd = 0;
        repeat (4) begin
            @(negedge clock);
            if (mem_rd === 1'b1) n_rd++;
        end
        check("t5_reads_halted", n_rd, 0);
        check("t5_drained", instr_valid, 0);
        step(1);
        halt = 1'b0;
        #1;
        check("t5_bubble_rd", mem_rd, 0);
        step(1);
        check("t5_resume_rd", mem_rd, 1);
        check("t5_resume_addr", mem_addr, 8'h23);
        step(3);
        halt = 1'b1;
        step(2);
        redirect    = 1'b1;
        redirect_pc = 8'h60;
        #1;
        check("t5_redir_rd", mem_rd, 0);
        step(1);
        redirect = 1'b0;
        halt     = 1'b0;
        #1;
        check("t5_redir_resume_rd", mem_rd, 1);
        check("t5_redir_resume_addr", mem_addr, 8'h60);
        step(3);

        // 6: reset with the buffer full
        instr_ready = 1'b0;
        step(3);
        check("t6_full_valid", instr_valid, 1);
        reset_n = 1'b0;
        step(1);
        check("t6_valid_after_rst", instr_valid, 0);
        check("t6_rd_in_rst", mem_rd, 0);
        reset_n     = 1'b1;
        instr_ready = 1'b1;
        #1;
        check("t6_rd_release", mem_rd, 1);
        check("t6_addr_release", mem_addr, 8'h00);
        step(6);

        @(negedge clock);
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fetch_unit
